// File: rtl/pdm_pkg.sv
// -----------------------------------------------------------------------------
// pdm_pkg
// Shared definitions for the PDM capture sequencer:
//   pdm_state_e    - capture FSM states, encoding visible on the state output
//   STARTUP_EDGES  - pdm_clk rising edges the microphone gets before the CIC
//                    is released from reset
//   DEF_*          - default widths/depths used by the top and the FIFO
// -----------------------------------------------------------------------------
package pdm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STARTUP = 2'd1,
      ST_SETTLE  = 2'd2,
      ST_RUN     = 2'd3
   } pdm_state_e;

   localparam int STARTUP_EDGES = 4;

   localparam int DEF_DEPTH    = 8;
   localparam int DEF_SAMPLE_W = 16;
   localparam int DEF_DIV_W    = 8;
   localparam int DEF_SETTLE_W = 8;

endpackage

// File: rtl/pdm_sample_fifo.sv
// -----------------------------------------------------------------------------
// pdm_sample_fifo
// Synchronous FIFO holding decimated PCM samples.
//   clk, rst   : clock, synchronous active-high reset
//   flush_i    : empties the FIFO (count and pointers to 0)
//   push_i     : write data_i; ignored when full unless pop_i is also set
//   pop_i      : advance the head; ignored when empty
//   data_i     : sample to write
//   data_o     : raw head entry (only meaningful when not empty)
//   count_o    : occupancy 0..DEPTH
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
// -----------------------------------------------------------------------------
module pdm_sample_fifo
   import pdm_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int W     = DEF_SAMPLE_W,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  data_i,
   output logic [W-1:0]  data_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

   // A push into a full FIFO is accepted only when a pop frees a slot in the
   // same cycle. A pop on an empty FIFO is dropped even if a push arrives,
   // so the pushed sample survives.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/pdm_capture_ctrl.sv
// -----------------------------------------------------------------------------
// pdm_capture_ctrl
// Capture sequencer for the PDM microphone: generates the gated PDM bit
// clock, holds the CIC in reset during mic startup, discards settling
// samples, buffers PCM samples in a FIFO and raises a level/overflow irq.
//   clk, rst       : system clock, synchronous active-high reset
//   cfg_enable     : capture enable
//   cfg_clk_div    : PDM clock period in clk cycles (< 2 is invalid)
//   cfg_settle     : PCM samples discarded after startup
//   cfg_irq_level  : FIFO fill threshold for irq, 0 disables the level term
//   pdm_clk        : registered PDM bit clock
//   cic_rst        : active-high reset to the CIC datapath
//   pcm_in/valid   : CIC output sample and its one-cycle strobe
//   rd_en          : pop one sample
//   rd_data        : FIFO head, 0 when empty
//   fifo_count     : occupancy 0..DEPTH
//   overflow       : sticky drop flag, cleared by ovf_clr (set wins)
//   state          : FSM state (0 IDLE, 1 STARTUP, 2 SETTLE, 3 RUN)
//   irq            : registered interrupt request
// -----------------------------------------------------------------------------
module pdm_capture_ctrl
   import pdm_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int DIV_W    = DEF_DIV_W,
   parameter int SETTLE_W = DEF_SETTLE_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_enable,
   input  logic [DIV_W-1:0]    cfg_clk_div,
   input  logic [SETTLE_W-1:0] cfg_settle,
   input  logic [4:0]          cfg_irq_level,
   output logic                pdm_clk,
   output logic                cic_rst,
   input  logic [SAMPLE_W-1:0] pcm_in,
   input  logic                pcm_valid,
   input  logic                rd_en,
   output logic [SAMPLE_W-1:0] rd_data,
   output logic [4:0]          fifo_count,
   output logic                overflow,
   input  logic                ovf_clr,
   output logic [1:0]          state,
   output logic                irq
);

   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = AW + 1;
   localparam int SCW = SETTLE_W + 1;

   pdm_state_e          state_q, state_d;
   logic [DIV_W-1:0]    phase_q, phase_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic                pdm_clk_q, pdm_clk_d;
   logic [2:0]          edge_cnt_q, edge_cnt_d;
   logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
   logic                ovf_q, ovf_d;
   logic                irq_q, irq_d;

   logic                div_valid;
   logic                go_idle;
   logic                phase_wrap;
   logic                pdm_rise;
   logic [SCW-1:0]      settle_next;
   logic                flush;
   logic                push;
   logic                drop;

   logic [SAMPLE_W-1:0] fifo_head;
   logic [CW-1:0]       fifo_cnt;
   logic                fifo_full;
   logic                fifo_empty;
   logic [4:0]          count_ext;

   assign div_valid  = (cfg_clk_div >= DIV_W'(2));
   assign go_idle    = !cfg_enable || !div_valid;
   assign phase_wrap = (phase_q == div_q - DIV_W'(1));

   // ---------------------------------------------------------------------------
   // Divider. div_q is the divisor in force; it only reloads from cfg_clk_div
   // in IDLE or at a phase wrap, so a period is never cut short mid-cycle.
   // The clock is computed from state_q so the first high edge lands one
   // cycle after STARTUP is entered; go_idle forces it low on the way out.
   // ---------------------------------------------------------------------------
   always_comb begin
      phase_d   = '0;
      pdm_clk_d = 1'b0;
      div_d     = div_q;
      if (state_q == ST_IDLE) begin
         div_d = cfg_clk_div;
      end else if (!go_idle) begin
         pdm_clk_d = (phase_q < (div_q >> 1));
         if (phase_wrap) begin
            phase_d = '0;
            div_d   = cfg_clk_div;
         end else begin
            phase_d = phase_q + DIV_W'(1);
         end
      end
   end

   assign pdm_rise = pdm_clk_d && !pdm_clk_q;

   // ---------------------------------------------------------------------------
   // Capture FSM, next state.
   // ---------------------------------------------------------------------------
   assign settle_next = {1'b0, settle_cnt_q} + SCW'(1);

   always_comb begin
      state_d      = state_q;
      flush        = 1'b0;
      edge_cnt_d   = edge_cnt_q;
      settle_cnt_d = settle_cnt_q;
      if (go_idle) begin
         state_d      = ST_IDLE;
         edge_cnt_d   = '0;
         settle_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d      = ST_STARTUP;
               flush        = 1'b1;
               edge_cnt_d   = '0;
               settle_cnt_d = '0;
            end
            ST_STARTUP: begin
               if (pdm_rise) begin
                  if (edge_cnt_q == 3'(STARTUP_EDGES - 1)) begin
                     state_d = (cfg_settle == '0) ? ST_RUN : ST_SETTLE;
                  end else begin
                     edge_cnt_d = edge_cnt_q + 3'd1;
                  end
               end
            end
            ST_SETTLE: begin
               // The strobe that completes the count is itself discarded.
               if (pcm_valid) begin
                  if (settle_next >= {1'b0, cfg_settle}) begin
                     state_d = ST_RUN;
                  end else begin
                     settle_cnt_d = settle_next[SETTLE_W-1:0];
                  end
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO, overflow and irq.
   // ---------------------------------------------------------------------------
   assign push = (state_q == ST_RUN) && pcm_valid;
   assign drop = push && fifo_full && !rd_en;

   pdm_sample_fifo #(
      .DEPTH (DEPTH),
      .W     (SAMPLE_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .push_i  (push),
      .pop_i   (rd_en),
      .data_i  (pcm_in),
      .data_o  (fifo_head),
      .count_o (fifo_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign count_ext = 5'(fifo_cnt);

   always_comb begin
      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   // Built from registered count/overflow, so irq trails them by one cycle.
   // A threshold above DEPTH can never be reached by the count.
   always_comb begin
      irq_d = ovf_q;
      if ((cfg_irq_level != 5'd0) && (count_ext >= cfg_irq_level)) begin
         irq_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         phase_q      <= '0;
         div_q        <= '0;
         pdm_clk_q    <= 1'b0;
         edge_cnt_q   <= '0;
         settle_cnt_q <= '0;
         ovf_q        <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         div_q        <= div_d;
         pdm_clk_q    <= pdm_clk_d;
         edge_cnt_q   <= edge_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         ovf_q        <= ovf_d;
         irq_q        <= irq_d;
      end
   end

   assign pdm_clk    = pdm_clk_q;
   assign cic_rst    = (state_q == ST_IDLE) || (state_q == ST_STARTUP);
   assign rd_data    = fifo_empty ? '0 : fifo_head;
   assign fifo_count = count_ext;
   assign overflow   = ovf_q;
   assign state      = state_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
module tb_pdm_capture_ctrl;

   localparam int DEPTH    = 8;
   localparam int SAMPLE_W = 16;
   localparam int DIV_W    = 8;
   localparam int SETTLE_W = 8;

   // ---------------------------------------------------------------- clock/reset
   logic                clk;
   logic                rst;
   logic                cfg_enable;
   logic [DIV_W-1:0]    cfg_clk_div;
   logic [SETTLE_W-1:0] cfg_settle;
   logic [4:0]          cfg_irq_level;
   logic                pdm_clk;
   logic                cic_rst;
   logic [SAMPLE_W-1:0] pcm_in;
   logic                pcm_valid;
   logic                rd_en;
   logic [SAMPLE_W-1:0] rd_data;
   logic [4:0]          fifo_count;
   logic                overflow;
   logic                ovf_clr;
   logic [1:0]          state;
   logic                irq;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pdm_capture_ctrl #(
      .DEPTH    (DEPTH),
      .SAMPLE_W (SAMPLE_W),
      .DIV_W    (DIV_W),
      .SETTLE_W (SETTLE_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_enable    (cfg_enable),
      .cfg_clk_div   (cfg_clk_div),
      .cfg_settle    (cfg_settle),
      .cfg_irq_level (cfg_irq_level),
      .pdm_clk       (pdm_clk),
      .cic_rst       (cic_rst),
      .pcm_in        (pcm_in),
      .pcm_valid     (pcm_valid),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .fifo_count    (fifo_count),
      .overflow      (overflow),
      .ovf_clr       (ovf_clr),
      .state         (state),
      .irq           (irq)
   );

   // ---------------------------------------------------------------- scoreboard
   int n_vec = 0;
   int n_err = 0;
   logic [SAMPLE_W-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- drivers
   // Outputs are sampled 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_sample(input logic [SAMPLE_W-1:0] v);
      pcm_in    = v;
      pcm_valid = 1'b1;
      tick();
      pcm_valid = 1'b0;
   endtask

   task automatic pop_sample();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      rst           = 1'b1;
      cfg_enable    = 1'b0;
      cfg_clk_div   = 8'd4;
      cfg_settle    = 8'd3;
      cfg_irq_level = 5'd0;
      pcm_in        = '0;
      pcm_valid     = 1'b0;
      rd_en         = 1'b0;
      ovf_clr       = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset values
      check_eq("rst_state",    state,      0);
      check_eq("rst_pdm_clk",  pdm_clk,    0);
      check_eq("rst_cic_rst",  cic_rst,    1);
      check_eq("rst_count",    fifo_count, 0);
      check_eq("rst_overflow", overflow,   0);
      check_eq("rst_irq",      irq,        0);
      check_eq("rst_rd_data",  rd_data,    0);

      // Enable with div=4: STARTUP one cycle later, clock 2 high / 2 low,
      // SETTLE on the 4th rising edge (13 cycles after STARTUP entry).
      cfg_enable = 1'b1;
      tick();
      check_eq("en_state",   state,   1);
      check_eq("en_pdm_clk", pdm_clk, 0);
      check_eq("en_cic_rst", cic_rst, 1);
      for (int i = 1; i <= 13; i++) begin
         tick();
         check_eq($sformatf("startup_pdm_clk_%0d", i), pdm_clk, (((i - 1) % 4) < 2) ? 1 : 0);
         check_eq($sformatf("startup_state_%0d", i), state, (i < 13) ? 1 : 2);
      end
      check_eq("settle_cic_rst", cic_rst, 0);

      // Settle=3: samples 1..3 discarded, 4 and 5 stored
      push_sample(16'h0001);
      check_eq("settle_state_1", state, 2);
      push_sample(16'h0002);
      check_eq("settle_state_2", state, 2);
      push_sample(16'h0003);
      check_eq("settle_state_3", state, 3);
      check_eq("settle_count_0", fifo_count, 0);
      push_sample(16'h0004);
      push_sample(16'h0005);
      check_eq("run_count_2", fifo_count, 2);
      check_eq("run_head_4",  rd_data,    16'h0004);

      // Pops, including a pop when empty
      pop_sample();
      check_eq("pop1_head",  rd_data,    16'h0005);
      check_eq("pop1_count", fifo_count, 1);
      pop_sample();
      check_eq("pop2_count", fifo_count, 0);
      check_eq("pop2_head",  rd_data,    0);
      pop_sample();
      check_eq("pop_empty_count", fifo_count, 0);

      // Push and pop together on an empty FIFO: pop ignored
      pcm_in    = 16'h00AA;
      pcm_valid = 1'b1;
      rd_en     = 1'b1;
      tick();
      pcm_valid = 1'b0;
      rd_en     = 1'b0;
      check_eq("pp_empty_count", fifo_count, 1);
      check_eq("pp_empty_head",  rd_data,    16'h00AA);
      pop_sample();
      check_eq("pp_empty_drain", fifo_count, 0);

      // Fill to 8, then a 9th push drops and sets overflow
      for (int k = 0; k < 8; k++) push_sample(16'h0010 + 16'(k));
      check_eq("fill_count",    fifo_count, 8);
      check_eq("fill_overflow", overflow,   0);
      push_sample(16'h0018);
      check_eq("ovf_count", fifo_count, 8);
      check_eq("ovf_flag",  overflow,   1);
      check_eq("ovf_irq_lag", irq,      0);
      tick();
      check_eq("ovf_irq",  irq,     1);
      check_eq("ovf_head", rd_data, 16'h0010);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check_eq("clr_flag",    overflow, 0);
      check_eq("clr_irq_lag", irq,      1);
      tick();
      check_eq("clr_irq", irq, 0);

      // Full FIFO, push and pop together: count stays, head advances
      pcm_in    = 16'h0019;
      pcm_valid = 1'b1;
      rd_en     = 1'b1;
      tick();
      pcm_valid = 1'b0;
      rd_en     = 1'b0;
      check_eq("pp_full_count", fifo_count, 8);
      check_eq("pp_full_ovf",   overflow,   0);
      check_eq("pp_full_head",  rd_data,    16'h0011);

      // Drop and clear in the same cycle: set wins
      pcm_in    = 16'h0099;
      pcm_valid = 1'b1;
      ovf_clr   = 1'b1;
      tick();
      pcm_valid = 1'b0;
      ovf_clr   = 1'b0;
      check_eq("setwin_flag",  overflow,   1);
      check_eq("setwin_count", fifo_count, 8);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check_eq("setwin_clr", overflow, 0);

      // Drain and compare against the expected contents
      for (int k = 1; k <= 7; k++) exp_q.push_back(16'h0010 + 16'(k));
      exp_q.push_back(16'h0019);
      while (exp_q.size() > 0) begin
         check_eq("drain_data", rd_data, exp_q.pop_front());
         pop_sample();
      end
      check_eq("drain_count", fifo_count, 0);
      tick();
      check_eq("drain_irq", irq, 0);

      // Level irq at 3
      cfg_irq_level = 5'd3;
      push_sample(16'h00A1);
      push_sample(16'h00A2);
      push_sample(16'h00A3);
      check_eq("lvl_count_3", fifo_count, 3);
      check_eq("lvl_irq_lag", irq,        0);
      tick();
      check_eq("lvl_irq_on", irq, 1);
      pop_sample();
      check_eq("lvl_count_2",  fifo_count, 2);
      check_eq("lvl_irq_hold", irq,        1);
      tick();
      check_eq("lvl_irq_off", irq, 0);

      // Disable mid-RUN: contents retained and readable
      cfg_enable = 1'b0;
      tick();
      check_eq("dis_state",   state,      0);
      check_eq("dis_pdm_clk", pdm_clk,    0);
      check_eq("dis_cic_rst", cic_rst,    1);
      check_eq("dis_count",   fifo_count, 2);
      check_eq("dis_head",    rd_data,    16'h00A2);
      pop_sample();
      check_eq("dis_pop_head",  rd_data,    16'h00A3);
      check_eq("dis_pop_count", fifo_count, 1);

      // Re-enable flushes
      cfg_enable = 1'b1;
      tick();
      check_eq("reen_state", state,      1);
      check_eq("reen_count", fifo_count, 0);
      check_eq("reen_head",  rd_data,    0);

      // Invalid divider forces IDLE and keeps it there
      cfg_clk_div = 8'd1;
      tick();
      check_eq("div1_state_a", state, 0);
      tick();
      check_eq("div1_state_b", state,   0);
      check_eq("div1_pdm_clk", pdm_clk, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
